// File: rtl/shader_loader.sv
`default_nettype none
// ============================================================================
// Module   : shader_loader
// Brief    : SPI (mode 0, MSB first) program loader that appends each
//            received byte to the circular shader instruction memory and
//            passes executor shift requests through when no frame is active.
// Revision : 1.0 - initial release
// ============================================================================
module shader_loader #(
  parameter int NUM_INSTR = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spi_sclk_i,
  input  logic       spi_mosi_i,
  input  logic       spi_cs_ni,
  input  logic       exec_shift_i,
  output logic       shift_o,
  output logic       load_o,
  output logic [7:0] instr_o,
  output logic       loading_o,
  output logic       done_o
);

  localparam int                CNT_W    = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_INSTR - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [2:0]        sclk_sync;
  logic [1:0]        mosi_sync;
  logic [2:0]        cs_sync;
  logic [1:0]        primed;
  logic              armed;

  logic [2:0]        bit_cnt;
  logic [CNT_W-1:0]  byte_cnt;
  logic [7:0]        shreg;
  logic [7:0]        instr_q;

  logic              sclk_rise;
  logic              cs_fall;
  logic              cs_rise;
  logic [7:0]        byte_next;

  logic              frame_start;
  logic              take_bit;
  logic              abort;
  logic              commit;

  // Synchronise the SPI pins and track whether cs has genuinely been seen high
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync <= 3'b000;
      mosi_sync <= 2'b00;
      cs_sync   <= 3'b111;
      primed    <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_sclk_i};
      mosi_sync <= {mosi_sync[0], spi_mosi_i};
      cs_sync   <= {cs_sync[1:0], spi_cs_ni};
      // The cs synchroniser holds its reset value for two cycles; only a high
      // level actually sampled from the pin may arm frame detection, so a cs
      // held low across reset never looks like a falling edge.
      primed    <= {primed[0], 1'b1};
      armed     <= armed | (primed[1] & cs_sync[1]);
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2] & armed;
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign byte_next = {shreg[6:0], mosi_sync[1]};

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and memory command outputs
  always_comb begin
    state_next  = state;
    shift_o     = 1'b0;
    load_o      = 1'b0;
    loading_o   = 1'b0;
    done_o      = 1'b0;
    frame_start = 1'b0;
    take_bit    = 1'b0;
    abort       = 1'b0;
    commit      = 1'b0;
    case (state)
      IDLE: begin
        shift_o = exec_shift_i;
        if (cs_fall) begin
          frame_start = 1'b1;
          state_next  = RECV;
        end
      end
      RECV: begin
        loading_o = 1'b1;
        if (cs_rise) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (sclk_rise) begin
          take_bit = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_next = COMMIT;
          end
        end
      end
      COMMIT: begin
        loading_o  = 1'b1;
        shift_o    = 1'b1;
        load_o     = 1'b1;
        commit     = 1'b1;
        done_o     = (byte_cnt == LAST_IDX);
        state_next = cs_rise ? IDLE : RECV;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bit/byte counters, shift register and the registered output byte
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt  <= 3'd0;
      byte_cnt <= '0;
      shreg    <= 8'h00;
      instr_q  <= 8'h00;
    end else begin
      if (frame_start) begin
        bit_cnt  <= 3'd0;
        byte_cnt <= '0;
      end
      if (abort) begin
        bit_cnt <= 3'd0;
      end
      if (take_bit) begin
        shreg   <= byte_next;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          instr_q <= byte_next;
        end
      end
      if (commit) begin
        // Power-of-two depth: natural overflow gives the modulo wrap
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
    end
  end

  assign instr_o = instr_q;

endmodule
`default_nettype wire

// File: tb/tb_shader_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_shader_loader
// Brief    : Self-checking bench for shader_loader: reset/idle vector table,
//            directed multi-cycle sequences and randomized frames checked
//            against a queue of expected committed bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shader_loader;

  localparam int NUM_INSTR = 16;
  localparam int HALF      = 30;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       exec_shift;
  logic       shift;
  logic       load;
  logic [7:0] instr;
  logic       loading;
  logic       done;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // exec_shift source: 0 = manual value, 1 = pulse every 4 cycles, 2 = random
  int   exec_mode   = 0;
  logic manual_exec = 1'b0;
  int   cyc         = 0;
  bit   mon_en      = 1'b0;

  typedef struct {
    logic [7:0] b;
    logic       d;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] tx[$];

  typedef struct {
    logic       rst;
    logic       ex;
    logic       e_shift;
    logic       e_load;
    logic       e_loading;
    logic       e_done;
    logic [7:0] e_instr;
  } vec_t;
  vec_t vt[8];

  shader_loader #(.NUM_INSTR(NUM_INSTR)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .spi_sclk_i   (sclk),
    .spi_mosi_i   (mosi),
    .spi_cs_ni    (cs_n),
    .exec_shift_i (exec_shift),
    .shift_o      (shift),
    .load_o       (load),
    .instr_o      (instr),
    .loading_o    (loading),
    .done_o       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // exec_shift generator
  initial begin
    exec_shift = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (exec_mode)
        1:       exec_shift = (cyc % 4 == 0);
        2:       exec_shift = 1'($urandom % 2);
        default: exec_shift = manual_exec;
      endcase
      cyc++;
    end
  end

  // Reference model check: every shift&load pulse must consume the next
  // expected byte; outside a frame the executor request passes straight through.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!loading) begin
        check("passthru", {31'd0, shift}, {31'd0, exec_shift});
        check("idle_load", {31'd0, load}, 32'd0);
      end else begin
        check("stall", {31'd0, shift}, {31'd0, load});
      end
      if (shift && load) begin
        check("commit_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          check("instr", {24'd0, instr}, {24'd0, exp_q[0].b});
          check("done", {31'd0, done}, {31'd0, exp_q[0].d});
          void'(exp_q.pop_front());
        end
      end else begin
        check("done_idle", {31'd0, done}, 32'd0);
      end
    end
  end

  task automatic send_bits(input logic [7:0] b, input int n, input bit push, input logic d);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      #(HALF);
      if (push && i == 7) exp_q.push_back('{b: b, d: d});
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low(input bit chk);
    @(negedge clk);
    cs_n = 1'b0;
    if (chk) begin
      @(posedge clk); @(posedge clk); #1;
      check("cs_fall_lat2", {31'd0, loading}, 32'd0);
      @(posedge clk); #1;
      check("cs_fall_lat3", {31'd0, loading}, 32'd1);
    end else begin
      #40;
    end
  endtask

  task automatic cs_high(input bit chk);
    @(negedge clk);
    cs_n = 1'b1;
    if (chk) begin
      @(posedge clk); @(posedge clk); #1;
      check("cs_rise_lat2", {31'd0, loading}, 32'd1);
      @(posedge clk); #1;
      check("cs_rise_lat3", {31'd0, loading}, 32'd0);
    end
    #60;
  endtask

  task automatic frame(input int nbytes, input int pbits, input logic [7:0] pval, input bit chk);
    cs_low(chk);
    for (int k = 0; k < nbytes; k++)
      send_bits(tx[k], 8, 1'b1, ((k + 1) % NUM_INSTR) == 0);
    if (pbits > 0) send_bits(pval, pbits, 1'b0, 1'b0);
    #40;
    cs_high(chk);
    check("missing_commit", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b0;
    mosi  = 1'b0;
    cs_n  = 1'b1;

    // Reset and idle vectors: shift follows exec, everything else quiet
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      rst_n       = vt[i].rst;
      manual_exec = vt[i].ex;
      @(negedge clk);
      check("vec_shift",   {31'd0, shift},   {31'd0, vt[i].e_shift});
      check("vec_load",    {31'd0, load},    {31'd0, vt[i].e_load});
      check("vec_loading", {31'd0, loading}, {31'd0, vt[i].e_loading});
      check("vec_done",    {31'd0, done},    {31'd0, vt[i].e_done});
      check("vec_instr",   {24'd0, instr},   {24'd0, vt[i].e_instr});
    end
    manual_exec = 1'b0;
    mon_en      = 1'b1;
    repeat (4) @(posedge clk);

    // Full program in one frame, executor pulsing every 4 cycles (stall)
    exec_mode = 1;
    tx = '{8'h10, 8'h15, 8'h74, 8'hA0, 8'h3B, 8'hC2, 8'h5E, 8'h01,
           8'hFF, 8'h80, 8'h7F, 8'h66, 8'h99, 8'hD4, 8'h2C, 8'h40};
    frame(16, 0, 8'h00, 1'b1);
    repeat (10) @(posedge clk);

    // Abort: one full byte, five bits of 0xFF, then cs rises
    exec_mode = 0;
    tx = '{8'hA5};
    frame(1, 5, 8'hFF, 1'b0);
    tx = '{8'h3C};
    frame(1, 0, 8'h00, 1'b1);

    // Wrap: 17 bytes, done only on the 16th
    tx.delete();
    for (int k = 0; k < 17; k++) tx.push_back(8'($urandom));
    frame(17, 0, 8'h00, 1'b0);
    check("byte_cnt_wrap", {28'd0, dut.byte_cnt}, 32'd1);

    // Reset mid-frame with cs held low: nothing may commit until cs cycles
    cs_low(1'b0);
    send_bits(8'hE7, 3, 1'b0, 1'b0);
    #7 rst_n = 1'b0;
    #13 rst_n = 1'b1;
    check("rst_instr", {24'd0, instr}, 32'd0);
    send_bits(8'hE7, 5, 1'b0, 1'b0);
    send_bits(8'h5A, 8, 1'b0, 1'b0);
    check("rst_no_frame", {31'd0, loading}, 32'd0);
    cs_high(1'b0);
    check("rst_no_commit", exp_q.size(), 32'd0);
    tx = '{8'h3C};
    frame(1, 0, 8'h00, 1'b1);

    // Randomized frames with random executor activity and trailing partials
    exec_mode = 2;
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 20));
      tx.delete();
      for (int k = 0; k < n; k++) tx.push_back(8'($urandom));
      frame(n, int'($urandom_range(0, 7)), 8'($urandom), (r % 2) == 0);
      repeat (int'($urandom_range(2, 12))) @(posedge clk);
    end
    exec_mode = 0;
    repeat (5) @(posedge clk);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/shader_loader.md
# shader_loader

Serial program loader sitting directly upstream of the shader instruction memory. Receives program bytes over a mode-0 SPI-style link (MSB first), synchronises them into the system clock domain, and drives the memory's shift/load/instruction inputs so each received byte is appended to the circular instruction store. When no transfer is active, it passes the executor's per-instruction shift request straight through to the memory.

## Interface
- NUM_INSTR, 16, depth of the downstream instruction memory; power of two, ≥2; sets the byte-counter width to clog2(NUM_INSTR).
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- spi_sclk_i  in  1  serial clock, asynchronous; frequency ≤ clk_i/4.
- spi_mosi_i  in  1  serial data, asynchronous; sampled on rising spi_sclk_i.
- spi_cs_ni  in  1  chip select, asynchronous, active-low; frames a transfer.
- exec_shift_i  in  1  executor's shift request (one pulse per instruction consumed).
- shift_o  out  1  shift command to instruction memory.
- load_o  out  1  load command; when high with shift_o, instr_o enters the last memory slot.
- instr_o  out  8  byte to load.
- loading_o  out  1  high while a transfer is framed; executor must stall on it.
- done_o  out  1  one-cycle pulse each time NUM_INSTR bytes have been committed.

## Operation
- Input sync: 2-flop synchronisers on spi_sclk_i, spi_mosi_i and spi_cs_ni. Reset values are sclk 0, mosi 0, cs 1. A third flop on sclk and on cs provides edge detection.
- States: IDLE, RECV, COMMIT.
- IDLE
  - loading_o=0, load_o=0, shift_o=exec_shift_i (combinational pass-through), instr_o holds its last value.
  - A synchronised cs falling edge clears the bit and byte counters and moves to RECV.
  - A cs that is already low after reset is not a falling edge; stay in IDLE.
- RECV
  - loading_o=1. shift_o=0 and load_o=0; exec_shift_i is ignored.
  - On each synchronised sclk rising edge, shift the synchronised mosi into the LSB of the byte register (MSB first) and increment the 3-bit bit counter.
  - Capture of bit 8 moves to COMMIT.
  - A synchronised cs rising edge moves to IDLE, discarding any partial byte. The bit counter is cleared.
- COMMIT (exactly one cycle)
  - shift_o=1, load_o=1, instr_o=assembled byte.
  - Increment the byte counter modulo NUM_INSTR. If it wraps to 0, pulse done_o in the same cycle.
  - Return to RECV. If cs rose during the same cycle, the commit still completes and the next state is IDLE.
- The byte counter wraps. Bytes beyond NUM_INSTR keep loading and rotate the memory; done_o pulses again at every multiple of NUM_INSTR.
- instr_o is registered: the byte register value is latched on entry to COMMIT and held afterwards.

## Timing
- Reset: state IDLE, counters 0, byte register 0x00, instr_o 0x00, load_o 0, loading_o 0, done_o 0. shift_o=exec_shift_i.
- sclk rising edge at the pin → bit captured 3 clk edges later (2 sync + 1 detect).
- 8th bit captured at edge N → COMMIT (shift_o=load_o=1) in cycle N..N+1 → back in RECV at edge N+1.
- cs falling at the pin → loading_o high 3 clk edges later. cs rising at the pin → loading_o low 3 edges later.
- done_o is coincident with the COMMIT cycle of byte NUM_INSTR, 2·NUM_INSTR, …
- Reset asserted mid-transfer: everything returns to reset values immediately. The partial byte and byte count are lost. No new transfer starts until cs has gone high and then low again.
- Minimum sclk high and low time is 2 clk periods; faster sclk is out of spec.

## Test plan
- Reset: hold rst_ni low, toggle exec_shift_i → shift_o follows exec_shift_i; load_o, loading_o and done_o stay 0; instr_o=0x00.
- Full program: send 16 bytes 0x10,0x15,0x74,…,0x40 in one cs frame → 16 single-cycle shift_o&load_o pulses with instr_o matching each byte in order; one done_o pulse on the 16th; loading_o falls after cs rises.
- Abort: send 0xA5, then 5 bits of 0xFF, then raise cs → exactly one commit (0xA5), no done_o. The next frame's first byte 0x3C commits as 0x3C, with no bits leaking from the aborted byte.
- Stall: pulse exec_shift_i every 4 cycles during a frame → shift_o high only in COMMIT cycles. After cs rises, shift_o mirrors exec_shift_i again.
- Wrap: send 17 bytes → done_o once at byte 16; byte 17 commits normally; byte counter reads 1.
- Reset mid-frame: after 3 bits, pulse rst_ni low with cs held low → no commit occurs; further sclk edges are ignored until cs is cycled high then low.
